// File: rtl/nearhit_result_tx_pkg.sv
// Shared raytrace types for the nearest-hit path: FSM encoding, frame word
// indices and the hit record exchanged with the comparator.
package nearhit_result_tx_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  localparam logic [2:0] W_RAYID  = 3'd0;
  localparam logic [2:0] W_ANYHIT = 3'd1;
  localparam logic [2:0] W_THI    = 3'd2;
  localparam logic [2:0] W_TLO    = 3'd3;
  localparam logic [2:0] W_U      = 3'd4;
  localparam logic [2:0] W_V      = 3'd5;
  localparam logic [2:0] W_TRIID  = 3'd6;

  localparam int unsigned FRAME_HIT_LEN  = 7;
  localparam int unsigned FRAME_MISS_LEN = 2;

  typedef struct packed {
    logic [31:0] t;
    logic [15:0] u;
    logic [15:0] v;
    logic [15:0] triID;
    logic        anyhit;
  } hit_rec_t;

endpackage

// File: rtl/nearhit_word_mux.sv
// Selects the current frame word and its last flag from the captured hit
// record and the word index.
module nearhit_word_mux
  import nearhit_result_tx_pkg::*;
(
  input  logic [15:0] rayid_i,
  input  hit_rec_t    rec_i,
  input  logic [2:0]  idx_i,
  output logic [15:0] data_o,
  output logic        last_o
);

  always_comb begin
    data_o = '0;
    case (idx_i)
      W_RAYID:  data_o = rayid_i;
      W_ANYHIT: data_o = {rec_i.anyhit, 15'b0};
      W_THI:    data_o = rec_i.t[31:16];
      W_TLO:    data_o = rec_i.t[15:0];
      W_U:      data_o = rec_i.u;
      W_V:      data_o = rec_i.v;
      W_TRIID:  data_o = rec_i.triID;
      default:  data_o = '0;
    endcase
  end

  // A miss frame stops after the anyhit word.
  always_comb begin
    last_o = 1'b0;
    if (rec_i.anyhit)
      last_o = (32'(idx_i) == FRAME_HIT_LEN - 1);
    else
      last_o = (32'(idx_i) == FRAME_MISS_LEN - 1);
  end

endmodule

// File: rtl/nearhit_result_tx.sv
// Nearest-hit result transmitter: snapshots the comparator record on raydone,
// streams it as a framed word sequence and pulses clearnear to the comparator.
module nearhit_result_tx
  import nearhit_result_tx_pkg::*;
#(
  parameter int RAYID_W = 16,
  parameter int WORD_W  = 16
) (
  input  logic               clk,
  input  logic               globalreset,
  input  logic               raydone,
  input  logic [RAYID_W-1:0] rayid,
  input  logic [31:0]        t,
  input  logic [15:0]        u,
  input  logic [15:0]        v,
  input  logic [15:0]        triID,
  input  logic               anyhit,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               clearnear,
  output logic               busy,
  output logic               overrun,
  input  logic               clr_ovf
);

  tx_state_e    state_q;
  logic [2:0]   idx_q;
  logic [15:0]  rayid_q;
  hit_rec_t     rec_q;
  logic         clearnear_q;
  logic         overrun_q;

  logic [15:0]  mux_data;
  logic         mux_last;
  logic         sending;
  logic         xfer;
  logic         last_xfer;
  logic         capture;
  logic         drop;

  nearhit_word_mux u_word_mux (
    .rayid_i (rayid_q),
    .rec_i   (rec_q),
    .idx_i   (idx_q),
    .data_o  (mux_data),
    .last_o  (mux_last)
  );

  assign sending   = (state_q == ST_SEND);
  assign xfer      = sending & out_ready;
  assign last_xfer = xfer & mux_last;
  // Capture is also allowed on the final handshake for zero-bubble framing.
  assign capture   = raydone & (~sending | last_xfer);
  assign drop      = raydone & sending & ~last_xfer;

  always_ff @(posedge clk or posedge globalreset) begin
    if (globalreset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      rayid_q     <= '0;
      rec_q       <= '0;
      clearnear_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      clearnear_q <= capture;
      if (capture) begin
        state_q      <= ST_SEND;
        idx_q        <= '0;
        rayid_q      <= rayid;
        rec_q.t      <= t;
        rec_q.u      <= u;
        rec_q.v      <= v;
        rec_q.triID  <= triID;
        rec_q.anyhit <= anyhit;
      end else if (last_xfer) begin
        state_q <= ST_IDLE;
        idx_q   <= '0;
      end else if (xfer) begin
        idx_q <= idx_q + 3'd1;
      end

      if (drop)
        overrun_q <= 1'b1;
      else if (clr_ovf)
        overrun_q <= 1'b0;
    end
  end

  assign out_valid = sending;
  assign busy      = sending;
  assign out_data  = sending ? mux_data : '0;
  assign out_last  = sending & mux_last;
  assign clearnear = clearnear_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_nearhit_result_tx.sv
// Bench for nearhit_result_tx: directed cycle table, reset-mid-frame sequence
// and randomized traffic against a queue-based frame model.
module tb_nearhit_result_tx;

  logic        clk = 1'b0;
  logic        globalreset;
  logic        raydone;
  logic [15:0] rayid;
  logic [31:0] t;
  logic [15:0] u, v, triID;
  logic        anyhit;
  logic [15:0] out_data;
  logic        out_valid, out_ready, out_last, clearnear, busy, overrun, clr_ovf;

  int total = 0;
  int bad   = 0;

  nearhit_result_tx #(.RAYID_W(16), .WORD_W(16)) dut (
    .clk(clk), .globalreset(globalreset), .raydone(raydone), .rayid(rayid),
    .t(t), .u(u), .v(v), .triID(triID), .anyhit(anyhit),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .clearnear(clearnear), .busy(busy),
    .overrun(overrun), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] H_T   = 32'h0001_8000;
  localparam logic [15:0] H_U   = 16'h1234;
  localparam logic [15:0] H_V   = 16'h0567;
  localparam logic [15:0] H_TRI = 16'h00AB;

  typedef struct {
    logic        rd;
    logic [15:0] rid;
    logic        ah;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [15:0] ed;
    logic        el;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rd, logic [15:0] rid, logic ah, logic rdy, logic clr,
                              logic ev, logic [15:0] ed, logic el, logic ec, logic eo);
    vec_t r;
    r.rd = rd; r.rid = rid; r.ah = ah; r.rdy = rdy; r.clr = clr;
    r.ev = ev; r.ed = ed; r.el = el; r.ec = ec; r.eo = eo;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Non-capturing cycles drive random comparator values to prove isolation.
  task automatic set_in(input logic rd, input logic [15:0] rid, input logic [31:0] tt,
                        input logic [15:0] uu, input logic [15:0] vv, input logic [15:0] tri_,
                        input logic ah, input logic rdy, input logic clr);
    raydone = rd; out_ready = rdy; clr_ovf = clr;
    if (rd) begin
      rayid = rid; t = tt; u = uu; v = vv; triID = tri_; anyhit = ah;
    end else begin
      rayid = 16'($urandom); t = $urandom; u = 16'($urandom);
      v = 16'($urandom); triID = 16'($urandom); anyhit = 1'($urandom);
    end
  endtask

  // Reference model: the pending words of the frame in flight.
  logic [15:0] mq[$];
  logic        m_clear;
  logic        m_ovf;

  task automatic model_reset();
    mq.delete(); m_clear = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    logic was_valid, done, cap;
    was_valid = (mq.size() > 0);
    done = 1'b0;
    if (was_valid && out_ready) begin
      void'(mq.pop_front());
      done = (mq.size() == 0);
    end
    cap = raydone && (!was_valid || done);
    m_clear = cap;
    if (cap) begin
      mq.push_back(rayid);
      mq.push_back(anyhit ? 16'h8000 : 16'h0000);
      if (anyhit) begin
        mq.push_back(t[31:16]); mq.push_back(t[15:0]);
        mq.push_back(u); mq.push_back(v); mq.push_back(triID);
      end
    end
    if (raydone && !cap) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
  endtask

  task automatic model_check();
    logic ev;
    ev = (mq.size() > 0);
    chk("rnd_valid", 32'(out_valid), 32'(ev));
    chk("rnd_busy", 32'(busy), 32'(ev));
    if (ev) begin
      chk("rnd_data", 32'(out_data), 32'(mq[0]));
      chk("rnd_last", 32'(out_last), 32'(mq.size() == 1));
    end
    chk("rnd_clearnear", 32'(clearnear), 32'(m_clear));
    chk("rnd_overrun", 32'(overrun), 32'(m_ovf));
  endtask

  initial begin
    globalreset = 1'b1;
    set_in(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_clearnear", 32'(clearnear), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    repeat (2) @(posedge clk);
    #1 globalreset = 1'b0;

    // Hit frame with ready high
    tbl.push_back(mk(1, 16'h0042, 1, 1, 0,  0, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h0042, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h8000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h8000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h1234, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h0567, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h00AB, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 16'h0000, 0, 0, 0));
    // Miss frame
    tbl.push_back(mk(1, 16'h0007, 0, 1, 0,  0, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h0007, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 16'h0000, 0, 0, 0));
    // Backpressure on w3, then back-to-back miss on the w6 transfer
    tbl.push_back(mk(1, 16'h0042, 1, 1, 0,  0, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h0042, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h8000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 16'h8000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 16'h8000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, 16'h8000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h8000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h1234, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h0567, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0043, 0, 1, 0,  1, 16'h00AB, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h0043, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 16'h0000, 0, 0, 0));
    // Drop during w2, drop with clr_ovf (set wins), then clr_ovf alone
    tbl.push_back(mk(1, 16'h0042, 1, 1, 0,  0, 16'h0000, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h0042, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h8000, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0099, 0, 1, 0,  1, 16'h0001, 0, 0, 0));
    tbl.push_back(mk(1, 16'h0099, 0, 1, 1,  1, 16'h8000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h1234, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1,  1, 16'h0567, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0,  1, 16'h00AB, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 16'h0000, 0, 0, 0));

    foreach (tbl[i]) begin
      set_in(tbl[i].rd, tbl[i].rid, H_T, H_U, H_V, H_TRI, tbl[i].ah, tbl[i].rdy, tbl[i].clr);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(tbl[i].ed));
      chk($sformatf("vec%0d_last", i), 32'(out_last), 32'(tbl[i].el));
      chk($sformatf("vec%0d_clearnear", i), 32'(clearnear), 32'(tbl[i].ec));
      chk($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(tbl[i].eo));
      @(posedge clk); #1;
    end

    // Reset mid-frame: drop at w2 to set overrun, assert reset during w4
    set_in(1'b1, 16'h0055, H_T, H_U, H_V, H_TRI, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_in(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 set_in(1'b1, 16'h0066, H_T, H_U, H_V, H_TRI, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_in(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_data_w4", 32'(out_data), 32'(H_U));
    chk("pre_rst_overrun", 32'(overrun), 1);
    globalreset = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_last", 32'(out_last), 0);
    chk("midrst_overrun", 32'(overrun), 0);
    @(posedge clk); #1 globalreset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'($urandom), 1'b0);
      @(negedge clk);
      chk("postrst_valid", 32'(out_valid), 0);
      chk("postrst_clearnear", 32'(clearnear), 0);
      @(posedge clk); #1;
    end

    // Randomized traffic against the frame model
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom_range(0, 5) == 0), 16'($urandom), $urandom, 16'($urandom),
             16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 9) < 7),
             ($urandom_range(0, 19) == 0));
      @(negedge clk);
      model_check();
      model_step();
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
